xbus_dma: RTL and testbench
===========================

// Module: xbus_dma
// PURPOSE
//   xbus initiator that copies a block of 32-bit words from a source region to a
//   destination region (e.g. boot image from rom into data ram) through xbus slaves.
//   xbus slaves answer combinationally: xbus_rdata is valid in the same cycle as xbus_cs.
//   Sits beside the CPU; an external arbiter grants it the bus via xbus_req/xbus_gnt.
//   Software starts a transfer with start/src/dst/len and waits for busy low or done.
// PARAMETERS
//   LEN_W   16   width of len; max transfer is 2**LEN_W-1 words
// PORTS
//   clk         in   1      system clock, all state updates on rising edge
//   rst         in   1      asynchronous, active-high reset
//   start       in   1      1-cycle request; samples src_addr/dst_addr/len when idle
//   src_addr    in   32     source byte address; bits [1:0] ignored (forced 0)
//   dst_addr    in   32     destination byte address; bits [1:0] ignored (forced 0)
//   len         in   LEN_W  number of words to copy
//   busy        out  1      transfer in progress (READ or WRITE state)
//   done        out  1      1-cycle pulse when transfer finishes
//   xbus_req    out  1      bus request to arbiter
//   xbus_gnt    in   1      bus grant; access happens only in cycles with req&gnt
//   xbus_cs     out  1      slave select, = xbus_req & xbus_gnt
//   xbus_we     out  1      1 = write access
//   xbus_be     out  4      byte enables; 4'hF on writes, 4'h0 on reads
//   xbus_addr   out  32     access address
//   xbus_wdata  out  32     write data
//   xbus_rdata  in   32     read data from selected slave, same cycle
// BEHAVIOUR
//   States: IDLE, READ, WRITE, DONE. Registers: src_q, dst_q, remain_q, data_q.
//   Reset (async): state=IDLE; busy=done=xbus_req=xbus_cs=xbus_we=0; xbus_be=0;
//     xbus_addr=0; xbus_wdata=0; all internal registers cleared.
//   IDLE: start=1 & len!=0 -> latch {src[31:2],2'b0},{dst[31:2],2'b0},len; -> READ.
//     start=1 & len==0 -> DONE (no bus access). start=0 -> stay.
//   READ: xbus_req=1, we=0, be=0, addr=src_q. If gnt: data_q<=xbus_rdata,
//     src_q<=src_q+4 -> WRITE. If !gnt: hold all outputs, no state change.
//   WRITE: xbus_req=1, we=1, be=4'hF, addr=dst_q, wdata=data_q. If gnt:
//     dst_q<=dst_q+4, remain_q<=remain_q-1; remain_q==1 -> DONE else -> READ.
//     If !gnt: hold.
//   DONE: done=1 for exactly one cycle -> IDLE. busy=0 in IDLE and DONE.
//   xbus_addr/xbus_wdata/xbus_we/xbus_be are 0 whenever xbus_req=0.
//   Latency with gnt tied 1: start sampled at edge 0 -> READ cycle 1, WRITE cycle 2,
//     ..., last WRITE cycle 2N, done pulse cycle 2N+1; busy high cycles 1..2N.
//   start while busy or in DONE is ignored (no re-latch, no queueing).
//   Addresses increment modulo 2**32 (0xFFFFFFFC + 4 -> 0x00000000).
//   Overlapping regions are copied in ascending order, word-by-word read-then-write.
//   gnt dropped mid-transfer stalls in the current state; the pending access is
//     retried unchanged when gnt returns; no word is skipped or duplicated.
//   rst asserted mid-transfer: returns to IDLE immediately, no further bus cycles,
//     no done pulse; words already written stay written.
// TESTING
//   1) gnt=1, src=0x0, dst=0x1000, len=3, model ROM words A,B,C -> writes
//      0x1000=A @cyc2, 0x1004=B @cyc4, 0x1008=C @cyc6; done=1 only at cyc7.
//   2) start with len=0 -> no xbus_cs ever, done=1 exactly one cycle after start.
//   3) gnt toggles 1,0,0,1,... during len=4 -> exactly 4 reads + 4 writes, correct
//      data/addresses, outputs stable while gnt=0, done after last granted write.
//   4) src=0x3, dst=0xFFFFFFFE, len=2 -> reads 0x0,0x4; writes 0xFFFFFFFC,0x0.
//   5) second start pulse while busy with different args -> ignored; original
//      transfer completes unchanged; single done pulse.
//   6) rst asserted at cycle 3 of len=4 transfer -> same-cycle outputs all 0,
//      state IDLE, no done; new start afterwards runs normally.

Source files
------------

// File: rtl/xbus_dma.sv
// xbus_dma: xbus initiator copying a block of 32-bit words from src to dst.
// Each word is a granted read followed by a granted write; all bus outputs
// except xbus_cs are registered, xbus_cs qualifies the request with the grant.
module xbus_dma #(
   parameter int unsigned LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             xbus_req,
   input  logic             xbus_gnt,
   output logic             xbus_cs,
   output logic             xbus_we,
   output logic [3:0]       xbus_be,
   output logic [31:0]      xbus_addr,
   output logic [31:0]      xbus_wdata,
   input  logic [31:0]      xbus_rdata
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    src_q, src_d;
   logic [AW-1:0]    dst_q, dst_d;
   logic [LEN_W-1:0] remain_q, remain_d;
   logic [DW-1:0]    data_q, data_d;

   logic             busy_d, done_d, req_d, we_d;
   logic [3:0]       be_d;
   logic [AW-1:0]    addr_d;
   logic [DW-1:0]    wdata_d;

   // Byte-offset bits of the addresses are dropped on purpose.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

   // A slave is selected only in cycles where the request is granted.
   assign xbus_cs = xbus_req & xbus_gnt;

   // Next-state, datapath and next-output decode.
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      remain_d = remain_q;
      data_d   = data_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  src_d    = {src_addr[AW-1:2], 2'b00};
                  dst_d    = {dst_addr[AW-1:2], 2'b00};
                  remain_d = len;
                  state_d  = S_READ;
               end else begin
                  state_d  = S_DONE;
               end
            end
         end
         S_READ: begin
            if (xbus_gnt) begin
               data_d  = xbus_rdata;
               src_d   = src_q + AW'(4);
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (xbus_gnt) begin
               dst_d    = dst_q + AW'(4);
               remain_d = remain_q - LEN_W'(1);
               state_d  = (remain_q == LEN_W'(1)) ? S_DONE : S_READ;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d  = (state_d == S_READ) || (state_d == S_WRITE);
      done_d  = (state_d == S_DONE);
      req_d   = busy_d;
      we_d    = (state_d == S_WRITE);
      be_d    = we_d ? 4'hF : 4'h0;
      addr_d  = (state_d == S_READ)  ? src_d :
                (state_d == S_WRITE) ? dst_d : '0;
      wdata_d = we_d ? data_d : '0;
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         remain_q   <= '0;
         data_q     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         xbus_req   <= 1'b0;
         xbus_we    <= 1'b0;
         xbus_be    <= '0;
         xbus_addr  <= '0;
         xbus_wdata <= '0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         remain_q   <= remain_d;
         data_q     <= data_d;
         busy       <= busy_d;
         done       <= done_d;
         xbus_req   <= req_d;
         xbus_we    <= we_d;
         xbus_be    <= be_d;
         xbus_addr  <= addr_d;
         xbus_wdata <= wdata_d;
      end
   end

endmodule

// File: tb/tb_xbus_dma.sv
// Bench for xbus_dma: a memory model answers reads, a reference copy of the
// memory predicts every read and write, and a grant pattern per transfer
// predicts when done must pulse.
module tb_xbus_dma;

   localparam int unsigned LEN_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [31:0]      src_addr, dst_addr;
   logic [LEN_W-1:0] len;
   logic             busy, done, xbus_req, xbus_gnt, xbus_cs, xbus_we;
   logic [3:0]       xbus_be;
   logic [31:0]      xbus_addr, xbus_wdata, xbus_rdata;

   xbus_dma #(.LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .src_addr(src_addr),
      .dst_addr(dst_addr), .len(len), .busy(busy), .done(done),
      .xbus_req(xbus_req), .xbus_gnt(xbus_gnt), .xbus_cs(xbus_cs),
      .xbus_we(xbus_we), .xbus_be(xbus_be), .xbus_addr(xbus_addr),
      .xbus_wdata(xbus_wdata), .xbus_rdata(xbus_rdata)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int base = 0;
   bit rec  = 1'b0;
   bit gpat [0:255];

   logic [31:0] mem  [logic [31:0]];
   logic [31:0] emem [logic [31:0]];

   logic [31:0] act_rd[$], act_wa[$], act_wd[$];
   logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
   int          done_at[$];
   int          busy_cnt;

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      int          n;
      int          gmode;
      bit          restart;
   } vec_t;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : dflt(a);
   endfunction

   function automatic logic [31:0] rd_emem(input logic [31:0] a);
      return emem.exists(a) ? emem[a] : dflt(a);
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Grant and slave read data for the current cycle.
   always @(negedge clk) begin
      int idx;
      idx = cyc - base;
      xbus_gnt   = (rec && idx >= 0 && idx < 256) ? gpat[idx] : 1'b1;
      xbus_rdata = (xbus_req && !xbus_we) ? rd_mem(xbus_addr) : 32'hDEAD_BEEF;
   end

   // Bus monitor: records accesses, applies writes, checks per-cycle rules.
   logic        p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0;
   logic [31:0] p_addr = '0, p_wdata = '0;
   always @(negedge clk) begin
      #1;
      if (xbus_cs && xbus_we) mem[xbus_addr] = xbus_wdata;
      if (rec) begin
         if (xbus_cs && !xbus_we) act_rd.push_back(xbus_addr);
         if (xbus_cs && xbus_we) begin
            act_wa.push_back(xbus_addr);
            act_wd.push_back(xbus_wdata);
         end
         if (done) done_at.push_back(cyc - base);
         if (busy) busy_cnt++;
      end
      check("cs_eq_req_and_gnt", 32'(xbus_cs), 32'(xbus_req & xbus_gnt));
      check("req_eq_busy", 32'(xbus_req), 32'(busy));
      if (!xbus_req) begin
         check("idle_addr", xbus_addr, 32'h0);
         check("idle_wdata", xbus_wdata, 32'h0);
         check("idle_we_be", {27'h0, xbus_we, xbus_be}, 32'h0);
      end else begin
         check("be_vs_we", 32'(xbus_be), xbus_we ? 32'hF : 32'h0);
         if (!rst && p_req && !p_gnt) begin
            check("stall_addr", xbus_addr, p_addr);
            check("stall_we", 32'(xbus_we), 32'(p_we));
            check("stall_wdata", xbus_wdata, p_wdata);
         end
      end
      p_req = xbus_req; p_gnt = xbus_gnt; p_we = xbus_we;
      p_addr = xbus_addr; p_wdata = xbus_wdata;
   end

   task automatic build_gpat(input int gmode);
      gpat[0] = 1'b1;
      for (int k = 1; k < 256; k++) begin
         case (gmode)
            1:       gpat[k] = ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
            2:       gpat[k] = ($urandom_range(0, 9) < 6);
            default: gpat[k] = 1'b1;
         endcase
      end
   endtask

   task automatic clear_logs();
      act_rd.delete(); act_wa.delete(); act_wd.delete();
      exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
      done_at.delete();
      busy_cnt = 0;
   endtask

   task automatic run_xfer(input string nm, input vec_t v);
      logic [31:0] s, d, w;
      int exp_done, grants, k;
      build_gpat(v.gmode);
      clear_logs();
      // Reference: sequential ascending word copy on a snapshot of memory.
      emem = mem;
      s = v.src & 32'hFFFF_FFFC;
      d = v.dst & 32'hFFFF_FFFC;
      for (int i = 0; i < v.n; i++) begin
         w = rd_emem(s);
         exp_rd.push_back(s);
         emem[d] = w;
         exp_wa.push_back(d);
         exp_wd.push_back(w);
         s = s + 32'd4;
         d = d + 32'd4;
      end
      // Done follows the cycle holding the 2N-th granted access.
      if (v.n == 0) exp_done = 1;
      else begin
         grants = 0;
         k = 1;
         while (k < 255) begin
            if (gpat[k]) grants++;
            if (grants == 2 * v.n) break;
            k++;
         end
         exp_done = k + 1;
      end

      @(negedge clk);
      start = 1'b1; src_addr = v.src; dst_addr = v.dst; len = LEN_W'(v.n);
      base = cyc;
      rec = 1'b1;
      for (int c = 1; c < 300; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (v.restart && c == 3) begin
            start = 1'b1; src_addr = 32'h7700; dst_addr = 32'h8800; len = LEN_W'(9);
         end
         if (done_at.size() > 0 && c > done_at[0] + 3) break;
      end
      start = 1'b0;
      rec = 1'b0;

      check({nm, "_done_count"}, 32'(done_at.size()), 32'd1);
      if (done_at.size() > 0) begin
         check({nm, "_done_cycle"}, 32'(done_at[0]), 32'(exp_done));
         check({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(done_at[0] - 1));
      end
      check({nm, "_read_count"}, 32'(act_rd.size()), 32'(exp_rd.size()));
      check({nm, "_write_count"}, 32'(act_wa.size()), 32'(exp_wa.size()));
      for (int i = 0; i < exp_rd.size() && i < act_rd.size(); i++)
         check($sformatf("%s_rd%0d_addr", nm, i), act_rd[i], exp_rd[i]);
      for (int i = 0; i < exp_wa.size() && i < act_wa.size(); i++) begin
         check($sformatf("%s_wr%0d_addr", nm, i), act_wa[i], exp_wa[i]);
         check($sformatf("%s_wr%0d_data", nm, i), act_wd[i], exp_wd[i]);
      end
   endtask

   vec_t tbl [6];

   initial begin
      logic [31:0] w0;
      vec_t rv;

      tbl[0] = '{src: 32'h0000_0000, dst: 32'h0000_1000, n: 3, gmode: 0, restart: 1'b0};
      tbl[1] = '{src: 32'h0000_0040, dst: 32'h0000_0080, n: 0, gmode: 0, restart: 1'b0};
      tbl[2] = '{src: 32'h0000_0100, dst: 32'h0000_3000, n: 4, gmode: 1, restart: 1'b0};
      tbl[3] = '{src: 32'h0000_0003, dst: 32'hFFFF_FFFE, n: 2, gmode: 0, restart: 1'b0};
      tbl[4] = '{src: 32'h0000_0500, dst: 32'h0000_4000, n: 5, gmode: 0, restart: 1'b1};
      tbl[5] = '{src: 32'h0000_1000, dst: 32'h0000_1004, n: 4, gmode: 0, restart: 1'b0};

      rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
      xbus_gnt = 1'b1; xbus_rdata = '0;
      repeat (3) @(negedge clk);
      #2;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_req", 32'(xbus_req), 32'd0);
      check("reset_addr", xbus_addr, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) run_xfer($sformatf("tbl%0d", i), tbl[i]);

      // Reset in the middle of a transfer: cleared at once, nothing after.
      build_gpat(0);
      clear_logs();
      w0 = rd_mem(32'h200);
      @(negedge clk);
      start = 1'b1; src_addr = 32'h200; dst_addr = 32'h2000; len = LEN_W'(4);
      base = cyc;
      rec = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_done", 32'(done), 32'd0);
      check("rst_mid_req_cs", {30'h0, xbus_req, xbus_cs}, 32'd0);
      check("rst_mid_we_be", {27'h0, xbus_we, xbus_be}, 32'd0);
      check("rst_mid_addr", xbus_addr, 32'd0);
      check("rst_mid_wdata", xbus_wdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      rec = 1'b0;
      check("rst_mid_no_done", 32'(done_at.size()), 32'd0);
      check("rst_mid_write_count", 32'(act_wa.size()), 32'd1);
      if (act_wa.size() > 0) begin
         check("rst_mid_wr0_addr", act_wa[0], 32'h2000);
         check("rst_mid_wr0_data", act_wd[0], w0);
      end
      run_xfer("after_rst", '{src: 32'h200, dst: 32'h2100, n: 3, gmode: 0, restart: 1'b0});

      // Randomized transfers with random grant patterns, some near the wrap.
      for (int r = 0; r < 12; r++) begin
         rv.src = $urandom;
         rv.dst = $urandom;
         if (r % 3 == 0) rv.src = 32'hFFFF_FFF0 | ($urandom & 32'hF);
         if (r % 4 == 1) rv.dst = 32'hFFFF_FFF4 | ($urandom & 32'h3);
         if (r % 5 == 2) rv.dst = rv.src + 32'd4;
         rv.n = $urandom_range(1, 6);
         rv.gmode = 2;
         rv.restart = (r % 4 == 3);
         run_xfer($sformatf("rand%0d", r), rv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
